// File: rtl/seq_detector_param.sv
// Serial matcher for a runtime-loadable PAT_W-bit pattern with overlap/non-overlap modes and a saturating match counter.
// Latency: detect_out rises one cycle after the edge that samples the final pattern bit. No backpressure: a bit is consumed whenever seq_valid is high.
module seq_detector_param #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1011,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_valid,
  input  logic             seq_in,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clr,
  output logic             detect_out,
  output logic [CNT_W-1:0] match_count,
  output logic [PAT_W-1:0] pattern
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  history_q, history_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              detect_q, detect_d;
  logic [PAT_W-1:0]  candidate;
  logic              match_now;

  always_comb begin
    history_d = history_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    count_d   = count_q;
    match_now = 1'b0;
    candidate = {history_q, seq_in};

    // A pattern load wins over a bit presented in the same cycle; that bit is dropped.
    if (pat_load) begin
      pattern_d = pat_in;
      history_d = '0;
      fill_d    = '0;
    end else if (seq_valid) begin
      history_d = candidate[PAT_W-2:0];
      match_now = (fill_q == FILL_MAX) && (candidate == pattern_q);
      if (match_now && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    // Clear beats a simultaneous match; the pulse still goes out.
    if (count_clr) begin
      count_d = '0;
    end else if (match_now && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end

    detect_d = match_now;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      history_q <= '0;
      fill_q    <= '0;
      pattern_q <= RESET_PAT;
      count_q   <= '0;
      detect_q  <= 1'b0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      count_q   <= count_d;
      detect_q  <= detect_d;
    end
  end

  assign detect_out  = detect_q;
  assign match_count = count_q;
  assign pattern     = pattern_q;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised successor to the fixed-pattern Moore sequence detector. It serially matches a runtime-loadable PAT_W-bit pattern on a qualified bit stream. It supports overlapping and non-overlapping detection, selectable at runtime, and keeps a saturating match counter. It sits between the serial input front-end and status/interrupt logic, and is the drop-in replacement wherever a fixed detector is used today.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..32).
RESET_PAT, 4'b1011, pattern register value after reset; PAT_W bits wide.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
seq_valid  input  1  qualifies seq_in; bit consumed only when high.
seq_in  input  1  serial data bit.
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
pat_load  input  1  load pat_in into the pattern register.
pat_in  input  PAT_W  new pattern; MSB is the first bit received.
count_clr  input  1  synchronous clear of match_count.
detect_out  output  1  one-cycle registered match pulse.
match_count  output  CNT_W  saturating count of detections.
pattern  output  PAT_W  current pattern register value.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous-to-clk deassert handled upstream):
  - detect_out=0, match_count=0, pattern=RESET_PAT.
  - history=0, fill=0.
  - Takes effect immediately, including mid-pattern.
- State:
  - history: PAT_W-1 bits.
  - fill: valid-bit count, saturating at PAT_W-1.
  - pattern register.
- Sampling (seq_valid=1, pat_load=0):
  - candidate = {history, seq_in}.
  - history <= candidate[PAT_W-2:0].
  - match_now = (fill == PAT_W-1) && (candidate == pattern).
  - seq_valid=0: no state change except outputs below; gaps never break a partial match.
- Output timing:
  - detect_out <= match_now on every edge, so it is high exactly one cycle, the cycle after the edge that sampled the final pattern bit.
  - detect_out is never high two cycles in a row unless consecutive valid bits each complete a match (overlap mode only; e.g. an all-ones pattern).
- Non-overlap (overlap_en=0): on match_now, fill <= 0; the next match needs PAT_W fresh bits. History content after a match is don't-care because fill gates it.
- Overlap (overlap_en=1): on match_now, fill stays at PAT_W-1; the shifted history continues.
  - overlap_en is sampled at the same edge as the bit; changes take effect for the next consumed bit.
- Fill: increments on each consumed bit while below PAT_W-1, otherwise holds (subject to the non-overlap clear).
- Pattern load: pat_load=1 loads pat_in into pattern and clears history and fill at that edge.
  - Any bit presented with seq_valid=1 in the same cycle is discarded: no match, no shift.
  - The new pattern applies from the next consumed bit.
- Counter:
  - On match_now, match_count increments, saturating at 2^CNT_W-1 (no wrap).
  - count_clr=1 forces 0 and has priority over a simultaneous match; that match is not counted, but detect_out still pulses.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset, default pattern 1011, overlap_en=0; bits 1,0,1,1 (valid each cycle) -> detect_out=1 in the cycle after the 4th bit edge only; match_count=1.
2. Stream 1,0,1,1,0,1,1 with overlap_en=0 -> one pulse (after bit 4), count=1. Same stream with overlap_en=1 -> pulses after bits 4 and 7, count=2.
3. Stream 1,0,1,1 with seq_valid low for 3 cycles between bits 2 and 3 -> single pulse after the 4th valid bit; fill unaffected by the gaps.
4. After bits 1,0 load pat_in=0110 with seq_valid=1, seq_in=1 the same cycle -> pattern=0110, that bit dropped. Then 0,1,1,0 -> pulse. Then 1,0,1,1 -> no pulse.
5. CNT_W=2 build, overlap_en=1, pattern 1111, ones stream -> count 1,2,3 then holds at 3 while detect_out pulses each bit. count_clr asserted on a match cycle -> count=0, detect_out still 1 next cycle.
6. Assert reset low mid-stream after 1,0,1 with a pattern 0110 loaded -> outputs 0 immediately, pattern=1011. After release, the bit 1 alone produces no pulse; a full 1,0,1,1 is required.
